// File: rtl/alu_arbiter.sv
// -----------------------------------------------------------------------------
// alu_arbiter
//
// Shares one combinational ALU among NREQ requesters. A round-robin arbiter
// picks one pending request in IDLE, latches that requester's operands onto
// the ALU inputs, lets the ALU settle for one cycle (EXEC), captures the
// result and presents it with a valid/ready handshake tagged by requester id
// (RESP). All outputs are registered.
//
// Optional build macro:
//   ALU_ARB_PRIO_EN  requester 0 becomes fixed high priority; the others
//                    arbitrate round-robin only when req[0] is low, and a
//                    win by requester 0 does not move last_winner.
//
// Ports:
//   clk         clock, rising edge
//   rst         synchronous active-high reset
//   req         per-requester request level
//   req_a/req_b flattened operands, requester i owns [i*DW +: DW]
//   req_sel     flattened opcodes, requester i owns [i*SW +: SW]
//   gnt         one-hot grant, high for the single EXEC cycle
//   alu_a/alu_b/alu_sel  operands/opcode driven to the shared ALU
//   alu_result  result returned by the shared ALU
//   rsp_valid/rsp_data/rsp_id  response, held until rsp_ready
//   rsp_ready   consumer accepts the response
//   busy        high whenever the FSM is not in IDLE
// -----------------------------------------------------------------------------
module alu_arbiter #(
  parameter int NREQ = 4,
  parameter int DW   = 4,
  parameter int SW   = 3,
  parameter int OW   = 8,
  parameter int IDW  = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req,
  input  logic [NREQ*DW-1:0]   req_a,
  input  logic [NREQ*DW-1:0]   req_b,
  input  logic [NREQ*SW-1:0]   req_sel,
  output logic [NREQ-1:0]      gnt,
  output logic [DW-1:0]        alu_a,
  output logic [DW-1:0]        alu_b,
  output logic [SW-1:0]        alu_sel,
  input  logic [OW-1:0]        alu_result,
  output logic                 rsp_valid,
  output logic [OW-1:0]        rsp_data,
  output logic [IDW-1:0]       rsp_id,
  input  logic                 rsp_ready,
  output logic                 busy
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] EXEC = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

`ifdef ALU_ARB_PRIO_EN
  localparam bit PRIO_EN = 1'b1;
`else
  localparam bit PRIO_EN = 1'b0;
`endif

  localparam logic [IDW:0] ONE_W  = (IDW+1)'(1);
  localparam logic [IDW:0] NREQ_W = (IDW+1)'(NREQ);

  logic [1:0]        state;
  logic [IDW-1:0]    last_winner;

  logic              any_req;
  logic [2*NREQ-1:0] dbl_req;
  logic [IDW:0]      shamt;
  logic [NREQ-1:0]   rot_req;
  logic [NREQ-1:0]   low_bit;
  logic [IDW:0]      offset;
  logic [IDW:0]      sum;
  logic [IDW-1:0]    winner;
  logic              update_last;
  int unsigned       widx;

  // Round-robin pick: rotate req so that bit 0 corresponds to last_winner+1,
  // isolate the lowest set bit, then map its position back to an index.
  always_comb begin
    any_req     = |req;
    dbl_req     = {req, req};
    shamt       = {1'b0, last_winner} + ONE_W;
    rot_req     = NREQ'(dbl_req >> shamt);
    low_bit     = rot_req & (~rot_req + NREQ'(1));
    offset      = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (low_bit == (NREQ'(1) << i)) offset = (IDW+1)'(i);
    end
    sum         = shamt + offset;
    if (sum >= NREQ_W) sum = sum - NREQ_W;
    winner      = IDW'(sum);
    update_last = 1'b1;
    if (PRIO_EN && req[0]) begin
      winner      = '0;
      update_last = 1'b0;
    end
    widx        = int'(winner);
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values; blocking here would create ordering races.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      last_winner <= IDW'(NREQ-1);
      gnt         <= '0;
      alu_a       <= '0;
      alu_b       <= '0;
      alu_sel     <= '0;
      rsp_valid   <= 1'b0;
      rsp_data    <= '0;
      rsp_id      <= '0;
      busy        <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (any_req) begin
            alu_a   <= DW'(req_a >> (widx * DW));
            alu_b   <= DW'(req_b >> (widx * DW));
            alu_sel <= SW'(req_sel >> (widx * SW));
            gnt     <= NREQ'(1) << winner;
            rsp_id  <= winner;
            if (update_last) last_winner <= winner;
            busy    <= 1'b1;
            state   <= EXEC;
          end
        end
        EXEC: begin
          // Operands were stable for a full cycle, so the ALU output is settled.
          rsp_data  <= alu_result;
          rsp_valid <= 1'b1;
          gnt       <= '0;
          state     <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          gnt       <= '0;
          rsp_valid <= 1'b0;
          busy      <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// -----------------------------------------------------------------------------
// tb_alu_arbiter
//
// Directed self-checking bench for alu_arbiter. The ALU is modelled as
// alu_result = {alu_a, alu_b}. Inputs are driven 1 time unit after each
// rising edge and outputs are sampled at the same point, away from the edge.
// Expectations follow the ALU_ARB_PRIO_EN build macro when it is defined.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_alu_arbiter;
  localparam int NREQ = 4;
  localparam int DW   = 4;
  localparam int SW   = 3;
  localparam int OW   = 8;
  localparam int IDW  = 2;

  logic                clk = 1'b0;
  logic                rst;
  logic [NREQ-1:0]     req;
  logic [NREQ*DW-1:0]  req_a;
  logic [NREQ*DW-1:0]  req_b;
  logic [NREQ*SW-1:0]  req_sel;
  logic [NREQ-1:0]     gnt;
  logic [DW-1:0]       alu_a;
  logic [DW-1:0]       alu_b;
  logic [SW-1:0]       alu_sel;
  logic [OW-1:0]       alu_result;
  logic                rsp_valid;
  logic [OW-1:0]       rsp_data;
  logic [IDW-1:0]      rsp_id;
  logic                rsp_ready;
  logic                busy;

  int errors = 0;
  int checks = 0;

  alu_arbiter #(.NREQ(NREQ), .DW(DW), .SW(SW), .OW(OW), .IDW(IDW)) dut (
    .clk        (clk),
    .rst        (rst),
    .req        (req),
    .req_a      (req_a),
    .req_b      (req_b),
    .req_sel    (req_sel),
    .gnt        (gnt),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_sel    (alu_sel),
    .alu_result (alu_result),
    .rsp_valid  (rsp_valid),
    .rsp_data   (rsp_data),
    .rsp_id     (rsp_id),
    .rsp_ready  (rsp_ready),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  assign alu_result = {alu_a, alu_b};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    req = '0;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst       = 1'b1;
    req       = 4'b1111;
    req_a     = 16'h5A5A;
    req_b     = 16'hA5A5;
    req_sel   = 12'hFFF;
    rsp_ready = 1'b0;
    tick();
    tick();
    checks++;
    if ({gnt, rsp_valid, busy} !== 6'b0) begin
      errors++;
      $display("FAIL reset_ctrl: gnt/valid/busy got %b want %b", {gnt, rsp_valid, busy}, 6'b0);
    end
    checks++;
    if ({alu_a, alu_b, alu_sel} !== 11'b0) begin
      errors++;
      $display("FAIL reset_alu: a/b/sel got %h want %h", {alu_a, alu_b, alu_sel}, 11'h0);
    end
    checks++;
    if ({rsp_data, rsp_id} !== 10'b0) begin
      errors++;
      $display("FAIL reset_rsp: data/id got %h want %h", {rsp_data, rsp_id}, 10'h0);
    end
    rst = 1'b0;
    req = '0;
    tick();
    checks++;
    if ({gnt, busy} !== 5'b0) begin
      errors++;
      $display("FAIL idle_no_req: gnt/busy got %b want %b", {gnt, busy}, 5'b0);
    end
  endtask

  task automatic test_single_op();
    req       = 4'b0100;
    req_a     = 16'h0A00;
    req_b     = 16'h0300;
    req_sel   = 12'h080;
    rsp_ready = 1'b1;
    tick();
    checks++;
    if ({gnt, busy, rsp_valid} !== {4'b0100, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL single_gnt: gnt/busy/valid got %b want %b", {gnt, busy, rsp_valid}, {4'b0100, 1'b1, 1'b0});
    end
    checks++;
    if ({alu_a, alu_b, alu_sel} !== {4'hA, 4'h3, 3'b010}) begin
      errors++;
      $display("FAIL single_alu: a/b/sel got %h/%h/%b want a/3/010", alu_a, alu_b, alu_sel);
    end
    req = '0;
    tick();
    checks++;
    if ({rsp_valid, rsp_id, rsp_data, gnt} !== {1'b1, 2'd2, 8'hA3, 4'b0}) begin
      errors++;
      $display("FAIL single_rsp: valid=%b id=%0d data=%h gnt=%b want 1/2/a3/0000", rsp_valid, rsp_id, rsp_data, gnt);
    end
    tick();
    checks++;
    if ({rsp_valid, busy} !== 2'b00) begin
      errors++;
      $display("FAIL single_done: valid/busy got %b want 00", {rsp_valid, busy});
    end
  endtask

  task automatic test_reset_mid_op();
    req   = 4'b0001;
    req_a = 16'h0007;
    req_b = 16'h0009;
    tick();
    checks++;
    if (gnt !== 4'b0001) begin
      errors++;
      $display("FAIL midop_gnt: gnt got %b want 0001", gnt);
    end
    rst = 1'b1;
    req = '0;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if ({rsp_valid, busy, gnt} !== 6'b0) begin
        errors++;
        $display("FAIL midop_quiet%0d: valid/busy/gnt got %b want 000000", i, {rsp_valid, busy, gnt});
      end
      tick();
    end
    // With last_winner back at NREQ-1, requester 0 beats requester 1.
    req = 4'b0011;
    tick();
    checks++;
    if ({gnt, rsp_id} !== {4'b0001, 2'd0}) begin
      errors++;
      $display("FAIL midop_lastwin: gnt=%b id=%0d want 0001/0", gnt, rsp_id);
    end
    req = '0;
    tick();
    tick();
  endtask

  task automatic test_round_robin();
    logic [IDW-1:0]  w;
    logic [NREQ-1:0] eg;
    logic [OW-1:0]   ed;
    apply_reset();
    req_a     = 16'h3210;
    req_b     = 16'hFEDC;
    req_sel   = {3'd3, 3'd2, 3'd1, 3'd0};
    req       = 4'b1111;
    rsp_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
`ifdef ALU_ARB_PRIO_EN
      w = 2'd0;
`else
      w = IDW'(k % NREQ);
`endif
      eg = 4'b0001 << w;
      ed = {2'b00, w, 4'hC + {2'b00, w}};
      tick();
      checks++;
      if ({gnt, alu_sel} !== {eg, 1'b0, w}) begin
        errors++;
        $display("FAIL rr_gnt%0d: gnt=%b sel=%0d want %b/%0d", k, gnt, alu_sel, eg, w);
      end
      tick();
      checks++;
      if ({rsp_valid, rsp_id, rsp_data, gnt} !== {1'b1, w, ed, 4'b0}) begin
        errors++;
        $display("FAIL rr_rsp%0d: valid=%b id=%0d data=%h gnt=%b want 1/%0d/%h/0000", k, rsp_valid, rsp_id, rsp_data, gnt, w, ed);
      end
      tick();
      checks++;
      if ({rsp_valid, busy, gnt} !== 6'b0) begin
        errors++;
        $display("FAIL rr_idle%0d: valid/busy/gnt got %b want 000000", k, {rsp_valid, busy, gnt});
      end
    end
    req = '0;
  endtask

  task automatic test_backpressure();
    logic [NREQ-1:0] eg;
    req       = 4'b0100;
    rsp_ready = 1'b0;
    tick();
    checks++;
    if (gnt !== 4'b0100) begin
      errors++;
      $display("FAIL bp_gnt: gnt got %b want 0100", gnt);
    end
    req = 4'b1111;
    tick();
    for (int i = 0; i < 6; i++) begin
      checks++;
      if ({rsp_valid, busy, rsp_id, rsp_data, gnt} !== {1'b1, 1'b1, 2'd2, 8'h2E, 4'b0}) begin
        errors++;
        $display("FAIL bp_hold%0d: valid=%b busy=%b id=%0d data=%h gnt=%b want 1/1/2/2e/0000", i, rsp_valid, busy, rsp_id, rsp_data, gnt);
      end
      if (i < 5) tick();
    end
    rsp_ready = 1'b1;
    tick();
    checks++;
    if ({rsp_valid, busy, gnt} !== 6'b0) begin
      errors++;
      $display("FAIL bp_release: valid/busy/gnt got %b want 000000", {rsp_valid, busy, gnt});
    end
`ifdef ALU_ARB_PRIO_EN
    eg = 4'b0001;
`else
    eg = 4'b1000;
`endif
    tick();
    checks++;
    if (gnt !== eg) begin
      errors++;
      $display("FAIL bp_next_gnt: gnt got %b want %b", gnt, eg);
    end
    req = '0;
    tick();
    tick();
  endtask

`ifdef ALU_ARB_PRIO_EN
  task automatic test_priority();
    logic [NREQ-1:0] exp_order [6];
    exp_order = '{4'b0010, 4'b0100, 4'b1000, 4'b0010, 4'b0001, 4'b0001};
    apply_reset();
    rsp_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      req = (k < 4) ? 4'b1110 : 4'b1111;
      tick();
      checks++;
      if (gnt !== exp_order[k]) begin
        errors++;
        $display("FAIL prio_gnt%0d: gnt got %b want %b", k, gnt, exp_order[k]);
      end
      tick();
      tick();
    end
    req = '0;
  endtask
`endif

  initial begin
    rst       = 1'b1;
    req       = '0;
    req_a     = '0;
    req_b     = '0;
    req_sel   = '0;
    rsp_ready = 1'b0;
    test_reset();
    test_single_op();
    test_reset_mid_op();
    test_round_robin();
    test_backpressure();
`ifdef ALU_ARB_PRIO_EN
    test_priority();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
